pmu_ahb_cnt: RTL
================

PMU_AHB_CNT -- requirements
Module: pmu_ahb_cnt

Interface
REQ-001 SHALL have parameter N_COUNTERS, default 9: number of event counters, legal range 1..30.
REQ-002 SHALL have parameter CNT_WIDTH, default 32: counter width, legal range 1..32; counters are zero-extended to 32 b on read.
REQ-003 SHALL have one clock and a synchronous, active-high reset, with no other clock or reset inputs.
REQ-004 SHALL have port clk_i, input, 1: clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: synchronous active-high reset.
REQ-006 SHALL have port hsel_i, input, 1: slave select.
REQ-007 SHALL have port haddr_i, input, 32: address; only bits [11:0] decoded.
REQ-008 SHALL have port hwrite_i, input, 1: 1 = write, 0 = read.
REQ-009 SHALL have port htrans_i, input, 2: transfer type; bit1 set = NONSEQ/SEQ.
REQ-010 SHALL have port hsize_i, input, 3: transfer size; only 3'b010 (word) legal.
REQ-011 SHALL have port hwdata_i, input, 32: write data, sampled in data phase.
REQ-012 SHALL have port hreadyi_i, input, 1: bus ready.
REQ-013 SHALL have port hreadyo_o, output, 1: slave ready.
REQ-014 SHALL have port hresp_o, output, 2: 2'b00 OKAY, 2'b01 ERROR.
REQ-015 SHALL have port hrdata_o, output, 32: read data.
REQ-016 SHALL have port hsplit_o, output, 16: tied to 0.
REQ-017 SHALL have port events_i, input, N_COUNTERS: one event strobe per counter, one count per high cycle.
REQ-018 SHALL have port irq_o, output, 1: OR of all overflow status bits.

Function
REQ-019 SHALL treat a transfer as accepted when hsel_i && hreadyi_i && htrans_i[1] in a cycle, latching address, direction and size for the data phase of the next cycle.
REQ-020 SHALL map word offsets as: 0x000 CFG (bit0 EN, bit1 CLR), 0x004 OVF status, 0x008 + 4*k counter k for k = 0..N_COUNTERS-1.
REQ-021 SHALL flag an accepted transfer as illegal if haddr_i[1:0] != 0, or hsize_i != 3'b010, or haddr_i[11:2] >= N_COUNTERS+2.
REQ-022 SHALL complete legal transfers with zero wait states: data phase hreadyo_o=1, hresp_o=00.
REQ-023 SHALL answer an illegal transfer with a two-cycle ERROR: cycle 1 hreadyo_o=0, hresp_o=01; cycle 2 hreadyo_o=1, hresp_o=01; no register is modified.
REQ-024 SHALL present read data in the data phase from current register state; hrdata_o SHALL be 0 for writes, idle cycles and errors.
REQ-025 SHALL perform writes in the data phase using hwdata_i; register update visible on the following cycle.
REQ-026 SHALL, for a CFG write, store bit0 to EN; bit1=1 clears all counters and OVF in that same update; CLR reads back 0.
REQ-027 SHALL make OVF write-1-to-clear; other OVF bits are unaffected.
REQ-028 SHALL, while EN=1, increment counter k by 1 on each cycle events_i[k]=1; SHALL hold all counters while EN=0.
REQ-029 SHALL wrap a counter from 2^CNT_WIDTH-1 to 0 and set OVF[k] in the same update.
REQ-030 SHALL, when a bus write to counter k coincides with events_i[k], load the written value (low CNT_WIDTH bits) and drop the event.
REQ-031 SHALL, when an OVF W1C write coincides with a new overflow of the same bit, leave the bit set.
REQ-032 SHALL ignore events and writes while a CFG CLR is applied in the same cycle; clear wins.
REQ-033 SHALL accept back-to-back transfers, including a read in the data phase immediately following a write to the same register (returns the pre-write value).
REQ-034 SHALL drive irq_o combinationally from the OVF register (no extra latency beyond OVF).

Reset
REQ-035 SHALL, on rst_i=1 at a rising edge, clear EN, OVF, all counters and any pending data-phase or ERROR state.
REQ-036 SHALL hold outputs while in reset at: hreadyo_o=1, hresp_o=00, hrdata_o=0, hsplit_o=0, irq_o=0.
REQ-037 SHALL, on reset asserted during an ERROR sequence, abandon it; the next cycle is idle OKAY.

Verification
REQ-038 SHALL be verified by: write CFG=0x1, hold events_i[0]=1 for 5 cycles, read 0x008 -> 5, OKAY, zero wait.
REQ-039 SHALL be verified by: CNT_WIDTH=4, write counter0=0xE, 2 events -> counter0=0x0, OVF=0x1, irq_o=1; write OVF=0x1 -> OVF=0, irq_o=0.
REQ-040 SHALL be verified by: read 0x001 and read with hsize_i=3'b000 -> each gives hreadyo_o 0 then 1 with hresp_o=01, registers unchanged.
REQ-041 SHALL be verified by: N_COUNTERS=9, read 0x02C -> ERROR; read 0x028 -> OKAY.
REQ-042 SHALL be verified by: write counter1=0x100 in the same cycle as events_i[1]=1 with EN=1 -> counter1=0x100.
REQ-043 SHALL be verified by: counters nonzero, write CFG=0x3 -> all counters 0, OVF 0, EN 1, CFG reads 0x1.

Source files
------------

// File: rtl/pmu_ahb_cnt.sv
// pmu_ahb_cnt: AHB-slave bank of event counters with a config word,
// a sticky overflow word (write-1-to-clear) and an overflow interrupt.
// Transfers are legal only as aligned word accesses within the register
// map; anything else gets a two-cycle ERROR and modifies nothing.
module pmu_ahb_cnt #(
    parameter int N_COUNTERS = 9,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  hsel_i,
    input  logic [31:0]           haddr_i,
    input  logic                  hwrite_i,
    input  logic [1:0]            htrans_i,
    input  logic [2:0]            hsize_i,
    input  logic [31:0]           hwdata_i,
    input  logic                  hreadyi_i,
    output logic                  hreadyo_o,
    output logic [1:0]            hresp_o,
    output logic [31:0]           hrdata_o,
    output logic [15:0]           hsplit_o,
    input  logic [N_COUNTERS-1:0] events_i,
    output logic                  irq_o
);

    localparam int         N_REGS   = N_COUNTERS + 2;
    localparam logic [9:0] LAST_IDX = 10'(N_REGS - 1);

    logic        accept;
    logic        illegal;
    logic [9:0]  addr_idx;

    logic        dp_valid_reg;
    logic        dp_write_reg;
    logic [9:0]  dp_idx_reg;
    logic        err1_reg;
    logic        err2_reg;
    logic        en_reg;
    logic [31:0] rd_data_reg;
    logic [31:0] rd_data_next;

    logic        wr_en;
    logic        cfg_wr;
    logic        ovf_wr;
    logic        clr;

    logic [N_COUNTERS-1:0]   ovf_vec;
    logic [N_REGS-1:0][31:0] rd_words;

    logic unused_ok;

    assign addr_idx = haddr_i[11:2];
    assign accept   = hsel_i && hreadyi_i && htrans_i[1];
    assign illegal  = (haddr_i[1:0] != 2'b00) || (hsize_i != 3'b010) ||
                      (addr_idx > LAST_IDX);

    // Address phase bookkeeping: latch a legal transfer for its data phase,
    // or start the two-cycle ERROR response for an illegal one.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dp_valid_reg <= 1'b0;
            dp_write_reg <= 1'b0;
            dp_idx_reg   <= '0;
            err1_reg     <= 1'b0;
            err2_reg     <= 1'b0;
        end else begin
            dp_valid_reg <= accept && !illegal;
            dp_write_reg <= hwrite_i;
            dp_idx_reg   <= addr_idx;
            err1_reg     <= accept && illegal;
            err2_reg     <= err1_reg;
        end
    end

    assign wr_en  = dp_valid_reg && dp_write_reg;
    assign cfg_wr = wr_en && (dp_idx_reg == 10'd0);
    assign ovf_wr = wr_en && (dp_idx_reg == 10'd1);
    assign clr    = cfg_wr && hwdata_i[1];

    // Enable bit; CLR is a pulse and is never stored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_reg <= 1'b0;
        end else if (cfg_wr) begin
            en_reg <= hwdata_i[0];
        end
    end

    assign rd_words[0] = {31'b0, en_reg};
    assign rd_words[1] = 32'(ovf_vec);

    generate
        for (genvar gi = 0; gi < N_COUNTERS; gi++) begin : g_cnt
            logic [CNT_WIDTH-1:0] cnt_reg;
            logic                 ovf_reg;
            logic                 cnt_wr;
            logic                 cnt_inc;
            logic                 wrap;

            // A bus write to the counter wins over a simultaneous event.
            assign cnt_wr  = wr_en && (dp_idx_reg == 10'(gi + 2));
            assign cnt_inc = en_reg && events_i[gi] && !cnt_wr;
            assign wrap    = cnt_inc && (&cnt_reg);

            // Counter: clear beats write beats increment.
            always_ff @(posedge clk_i) begin
                if (rst_i || clr) begin
                    cnt_reg <= '0;
                end else if (cnt_wr) begin
                    cnt_reg <= hwdata_i[CNT_WIDTH-1:0];
                end else if (cnt_inc) begin
                    cnt_reg <= cnt_reg + CNT_WIDTH'(1);
                end
            end

            // Sticky overflow flag; a new overflow beats a W1C in the same cycle.
            always_ff @(posedge clk_i) begin
                if (rst_i || clr) begin
                    ovf_reg <= 1'b0;
                end else if (wrap) begin
                    ovf_reg <= 1'b1;
                end else if (ovf_wr && hwdata_i[gi]) begin
                    ovf_reg <= 1'b0;
                end
            end

            assign ovf_vec[gi]       = ovf_reg;
            assign rd_words[gi + 2]  = 32'(cnt_reg);
        end
    endgenerate

    // Read mux on the address-phase index, so a read right after a write
    // to the same register captures the value from before that write.
    always_comb begin
        rd_data_next = '0;
        if (accept && !illegal && !hwrite_i) begin
            for (int i = 0; i < N_REGS; i++) begin
                if (addr_idx == 10'(i)) begin
                    rd_data_next = rd_words[i];
                end
            end
        end
    end

    // Read data register presented during the data phase.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_reg <= '0;
        end else begin
            rd_data_reg <= rd_data_next;
        end
    end

    assign hreadyo_o = rst_i || !err1_reg;
    assign hresp_o   = (!rst_i && (err1_reg || err2_reg)) ? 2'b01 : 2'b00;
    assign hrdata_o  = rst_i ? 32'd0 : rd_data_reg;
    assign hsplit_o  = 16'd0;
    assign irq_o     = !rst_i && (|ovf_vec);

    assign unused_ok = ^{haddr_i[31:12], htrans_i[0], hwdata_i};

endmodule
